// File: rtl/noc_packet_injector.sv
// noc_packet_injector
// Upstream stage of the 8x8 mesh. It collects neuron activations, each an 8-bit value plus a
// destination node, and buffers them in a small FIFO. It formats them as 16-bit NoC packets and
// injects at most one packet per cycle into the mesh local port. After each layer it sends one
// end-of-frame (EOF) marker packet.
//
// Packet layout: [15:14] tag (00 data, 11 EOF), [13:11] dst_x, [10:8] dst_y, [7:0] payload.
// The EOF payload is the frame number modulo 256.
//
// Ports
//   clk           rising-edge clock
//   i_reset_n     asynchronous active-low reset
//   i_act_valid   activation offered
//   i_act_data    activation value
//   i_act_dst     destination {x[2:0], y[2:0]}
//   o_act_ready   FIFO can accept (registered, low only when full)
//   i_frame_end   one-cycle pulse: current layer complete
//   o_pkt_data    packet to mesh
//   o_pkt_valid   packet valid
//   i_pkt_ready   mesh accepts the packet
//   o_fifo_count  activations currently buffered
//   o_pkt_count   packets injected since reset (data and EOF), wrapping
//   o_overflow    sticky: an activation was offered while o_act_ready was low
//
// FSM states
//   state  | meaning
//   S_IDLE | nothing buffered; waiting for activations or a pending frame end
//   S_SEND | draining the FIFO into the output register
//   S_EOF  | FIFO drained for the ending frame; EOF marker waits for a free output register
module noc_packet_injector #(
    parameter int         packet_size = 16,
    parameter int         xno         = 8,
    parameter int         yno         = 8,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [5:0] EOF_DST     = 6'd0,
    localparam int        DST_W       = $clog2(xno) + $clog2(yno),
    localparam int        CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   i_reset_n,
    input  logic                   i_act_valid,
    input  logic [7:0]             i_act_data,
    input  logic [DST_W-1:0]       i_act_dst,
    output logic                   o_act_ready,
    input  logic                   i_frame_end,
    output logic [packet_size-1:0] o_pkt_data,
    output logic                   o_pkt_valid,
    input  logic                   i_pkt_ready,
    output logic [CNT_W-1:0]       o_fifo_count,
    output logic [15:0]            o_pkt_count,
    output logic                   o_overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = DST_W + 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_EOF  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count, count_next;
    logic [7:0]       frame_num;
    logic             eof_pending;
    logic             wr_en, rd_en, load_eof, out_free, fifo_empty;

    assign wr_en        = i_act_valid & o_act_ready;
    assign fifo_empty   = (fifo_count == '0);
    // The output register can take a new packet when it is empty or its packet leaves this cycle.
    assign out_free     = !o_pkt_valid || i_pkt_ready;
    assign o_fifo_count = fifo_count;

    always_comb begin
        count_next = fifo_count;
        if (wr_en && !rd_en) begin
            count_next = fifo_count + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            count_next = fifo_count - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        load_eof   = 1'b0;
        case (state)
            S_IDLE, S_SEND: begin
                if (!fifo_empty) begin
                    rd_en = out_free;
                    // The FIFO empties after this load. An activation written in the same cycle
                    // as i_frame_end keeps the count up, so the EOF waits until that entry is sent.
                    if (rd_en && (fifo_count == CNT_W'(1)) && !wr_en) begin
                        state_next = (eof_pending || i_frame_end) ? S_EOF : S_IDLE;
                    end else begin
                        state_next = S_SEND;
                    end
                end else begin
                    state_next = eof_pending ? S_EOF : S_IDLE;
                end
            end
            S_EOF: begin
                if (out_free) begin
                    load_eof   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The storage array has no reset: entries become visible only through the reset pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {i_act_dst, i_act_data};
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            o_act_ready <= 1'b1;
            o_overflow  <= 1'b0;
            eof_pending <= 1'b0;
        end else begin
            state       <= state_next;
            fifo_count  <= count_next;
            o_act_ready <= (count_next != CNT_W'(FIFO_DEPTH));
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (i_act_valid && !o_act_ready) begin
                o_overflow <= 1'b1;
            end
            // A frame end that arrives while an EOF is still owed is merged into it.
            if (load_eof) begin
                eof_pending <= 1'b0;
            end else if (i_frame_end) begin
                eof_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pkt_data  <= '0;
            o_pkt_valid <= 1'b0;
            o_pkt_count <= '0;
            frame_num   <= '0;
        end else begin
            if (o_pkt_valid && i_pkt_ready) begin
                o_pkt_count <= o_pkt_count + 16'd1;
            end
            if (rd_en) begin
                o_pkt_data  <= {2'b00, fifo_mem[rd_ptr]};
                o_pkt_valid <= 1'b1;
            end else if (load_eof) begin
                o_pkt_data  <= {2'b11, EOF_DST, frame_num};
                o_pkt_valid <= 1'b1;
                frame_num   <= frame_num + 8'd1;
            end else if (i_pkt_ready) begin
                o_pkt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector. A scoreboard queue gets the expected packet when each
// activation or frame end is driven. A monitor pops the queue and compares on every packet transfer.
module tb_noc_packet_injector;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_act_valid;
    logic [7:0]  i_act_data;
    logic [5:0]  i_act_dst;
    logic        o_act_ready;
    logic        i_frame_end;
    logic [15:0] o_pkt_data;
    logic        o_pkt_valid;
    logic        i_pkt_ready;
    logic [3:0]  o_fifo_count;
    logic [15:0] o_pkt_count;
    logic        o_overflow;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_pushed = 0;
    logic [7:0]  frame_no = 8'd0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    noc_packet_injector dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_act_valid  (i_act_valid),
        .i_act_data   (i_act_data),
        .i_act_dst    (i_act_dst),
        .o_act_ready  (o_act_ready),
        .i_frame_end  (i_frame_end),
        .o_pkt_data   (o_pkt_data),
        .o_pkt_valid  (o_pkt_valid),
        .i_pkt_ready  (i_pkt_ready),
        .o_fifo_count (o_fifo_count),
        .o_pkt_count  (o_pkt_count),
        .o_overflow   (o_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_eof();
        exp_q.push_back({2'b11, 6'd0, frame_no});
        frame_no++;
        n_pushed++;
    endtask

    // Drives one activation that the bench knows will be accepted.
    task automatic act(input logic [7:0] d, input logic [5:0] dst, input logic fe);
        @(negedge clk);
        i_act_valid = 1'b1;
        i_act_data  = d;
        i_act_dst   = dst;
        i_frame_end = fe;
        exp_q.push_back({2'b00, dst, d});
        n_pushed++;
        if (fe) push_eof();
    endtask

    task automatic idle_in();
        @(negedge clk);
        i_act_valid = 1'b0;
        i_frame_end = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        @(negedge clk);
        i_pkt_ready = 1'b1;
        i_act_valid = 1'b0;
        i_frame_end = 1'b0;
        #1;
        while ((exp_q.size() != 0 || o_pkt_valid) && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_pkt_count"}, 32'(o_pkt_count), 32'(n_pushed));
    endtask

    // Scoreboard monitor. Inputs change only on the falling edge, so the transfer condition is
    // stable here.
    always begin
        @(negedge clk);
        #1;
        if (i_reset_n && o_pkt_valid && i_pkt_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_pkt: observed %0h expected none", o_pkt_data);
                end
            end else begin
                check("pkt_data", 32'(o_pkt_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n   = 1'b0;
        i_act_valid = 1'b0;
        i_act_data  = 8'd0;
        i_act_dst   = 6'd0;
        i_frame_end = 1'b0;
        i_pkt_ready = 1'b1;
        repeat (3) @(negedge clk);
        i_reset_n = 1'b1;
        #1;
        check("rst_valid",     32'(o_pkt_valid),  32'd0);
        check("rst_data",      32'(o_pkt_data),   32'd0);
        check("rst_act_ready", 32'(o_act_ready),  32'd1);
        check("rst_fifo_cnt",  32'(o_fifo_count), 32'd0);
        check("rst_pkt_cnt",   32'(o_pkt_count),  32'd0);
        check("rst_overflow",  32'(o_overflow),   32'd0);

        // Single activation: write on the first edge, load on the second, valid for one cycle.
        act(8'h7F, {3'd1, 3'd0}, 1'b0);
        idle_in();
        #1;
        check("t1_not_yet", 32'(o_pkt_valid), 32'd0);
        @(negedge clk);
        #1;
        check("t1_valid", 32'(o_pkt_valid), 32'd1);
        check("t1_data",  32'(o_pkt_data),  32'h087F);
        @(negedge clk);
        #1;
        check("t1_one_cycle", 32'(o_pkt_valid), 32'd0);
        check("t1_pkt_count", 32'(o_pkt_count), 32'd1);

        // Fill while the mesh stalls. The first activation moves into the empty output register,
        // so nine acceptances leave eight entries in the FIFO.
        @(negedge clk);
        i_pkt_ready = 1'b0;
        for (int i = 0; i < 9; i++) act(8'(8'hA0 + i), 6'(i * 7), 1'b0);
        @(negedge clk);
        i_act_valid = 1'b1;
        i_act_data  = 8'hEE;
        i_act_dst   = 6'h3F;
        #1;
        check("t2_full_ready", 32'(o_act_ready),  32'd0);
        check("t2_full_count", 32'(o_fifo_count), 32'd8);
        check("t2_no_ovf_yet", 32'(o_overflow),   32'd0);
        idle_in();
        #1;
        check("t2_overflow",   32'(o_overflow),   32'd1);
        check("t2_count_kept", 32'(o_fifo_count), 32'd8);
        @(negedge clk);
        i_pkt_ready = 1'b1;
        #1;
        check("t2_burst_valid", 32'(o_pkt_valid), 32'd1);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            #1;
            check("t2_burst_valid", 32'(o_pkt_valid), 32'd1);
        end
        @(negedge clk);
        #1;
        check("t2_after_valid", 32'(o_pkt_valid),  32'd0);
        check("t2_after_count", 32'(o_fifo_count), 32'd0);
        check("t2_after_ready", 32'(o_act_ready),  32'd1);
        check("t2_ovf_sticky",  32'(o_overflow),   32'd1);
        check("t2_pkt_count",   32'(o_pkt_count),  32'(n_pushed));

        // Frame 0: three activations then a separate frame end (EOF 16'hC000).
        act(8'h11, {3'd7, 3'd7}, 1'b0);
        act(8'h22, {3'd3, 3'd5}, 1'b0);
        act(8'h33, {3'd0, 3'd1}, 1'b0);
        @(negedge clk);
        i_act_valid = 1'b0;
        i_frame_end = 1'b1;
        push_eof();
        idle_in();
        drain("t3a");
        // Frame 1: the frame end shares a cycle with the last activation (EOF 16'hC001).
        act(8'h44, {3'd2, 3'd2}, 1'b0);
        act(8'h55, {3'd6, 3'd1}, 1'b1);
        idle_in();
        drain("t3b");

        // Ready toggling while activations stream in; a stalled packet is the scoreboard head.
        @(negedge clk);
        i_pkt_ready = 1'b0;
        i_act_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            i_pkt_ready = (k % 2 == 1);
            if (k < 6) begin
                i_act_valid = 1'b1;
                i_act_data  = 8'(8'h10 + k);
                i_act_dst   = 6'(k * 5);
                exp_q.push_back({2'b00, 6'(k * 5), 8'(8'h10 + k)});
                n_pushed++;
            end else begin
                i_act_valid = 1'b0;
            end
            #1;
            if (!i_pkt_ready && o_pkt_valid && exp_q.size() != 0)
                check("t4_stall_hold", 32'(o_pkt_data), 32'(exp_q[0]));
        end
        drain("t4");

        // Two frame ends while data is still buffered produce one EOF (frame 2) after the data.
        @(negedge clk);
        i_pkt_ready = 1'b0;
        act(8'h66, {3'd4, 3'd4}, 1'b0);
        act(8'h77, {3'd5, 3'd3}, 1'b0);
        @(negedge clk);
        i_act_valid = 1'b0;
        i_frame_end = 1'b1;
        push_eof();
        @(negedge clk);
        i_frame_end = 1'b0;
        @(negedge clk);
        i_frame_end = 1'b1;
        idle_in();
        drain("t5");

        // Asynchronous reset off the clock edge while a packet is held in the output register.
        @(negedge clk);
        i_pkt_ready = 1'b0;
        act(8'h88, {3'd1, 3'd1}, 1'b0);
        act(8'h99, {3'd2, 3'd3}, 1'b0);
        act(8'hAA, {3'd4, 3'd5}, 1'b0);
        @(negedge clk);
        i_act_valid = 1'b0;
        #1;
        check("t6_pre_valid", 32'(o_pkt_valid), 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("t6_rst_valid",     32'(o_pkt_valid),  32'd0);
        check("t6_rst_fifo_cnt",  32'(o_fifo_count), 32'd0);
        check("t6_rst_pkt_cnt",   32'(o_pkt_count),  32'd0);
        check("t6_rst_act_ready", 32'(o_act_ready),  32'd1);
        exp_q.delete();
        n_pushed = 0;
        frame_no = 8'd0;
        @(negedge clk);
        i_reset_n   = 1'b1;
        i_pkt_ready = 1'b1;
        act(8'h5A, {3'd1, 3'd2}, 1'b1);
        idle_in();
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
